// File: rtl/ram_dp_be.sv
// ---------------------------------------------------------------------------
// ram_dp_be
//
// Simple-dual-port RAM with one write port and one read port on a single
// clock. Writes are byte-enabled, the read path has a selectable latency of
// one or two cycles, and the behaviour of a read that hits the word being
// written in the same cycle is selectable. A clear engine zeroes the whole
// array after reset and on request. Both ports are locked out while it runs.
//
// Parameters
//   DATA_WIDTH   : word width in bits, multiple of 8
//   ADDR_WIDTH   : address width, DEPTH = 2**ADDR_WIDTH words
//   READ_LATENCY : 1 or 2 cycles from accepted rd_en to rd_valid/rd_data
//   RDW_MODE     : same-address read during write returns
//                  0 = the old word, 1 = the byte-merged new word
//
// Ports
//   clk      : clock, everything on the rising edge
//   rst      : asynchronous active-high reset, restarts the clear engine
//   clr      : request a clear of the whole array (ignored while busy)
//   busy     : clear engine running, requests on both ports are ignored
//   wr_en    : write request
//   wr_addr  : write address
//   wr_be    : byte enables, bit i covers wr_data[8i+7:8i]
//   wr_data  : write data
//   rd_en    : read request
//   rd_addr  : read address
//   rd_data  : read data, holds its last value between reads
//   rd_valid : one-cycle pulse marking a fresh rd_data
// ---------------------------------------------------------------------------
module ram_dp_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Clear engine FSM
    // -----------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    clear_active;
    logic                    wr_fire;
    logic                    rd_fire;

    assign clear_active = (state_q == ST_CLEAR);
    assign busy         = clear_active;

    // Requests are only honoured while the clear engine is idle. A read
    // accepted on the same edge that starts a clear still flows through the
    // pipeline, since the pipeline registers are independent of the FSM.
    assign wr_fire = wr_en & ~clear_active;
    assign rd_fire = rd_en & ~clear_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                // Last word is being zeroed this cycle; busy drops after the edge.
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Storage array
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // The clear engine owns the write port while it runs, so there is only
    // ever one write per cycle and the array maps onto a plain SDP RAM.
    always_ff @(posedge clk) begin
        if (clear_active) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read word selection (read-during-write policy)
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_word_d;
    logic                  rdw_hit;

    assign rdw_hit = wr_fire && (wr_addr == rd_addr);

    always_comb begin
        rd_word_d = mem_q[rd_addr];
        // In new-data mode a colliding write is forwarded around the array.
        if ((RDW_MODE != 0) && rdw_hit) begin
            rd_word_d = merge_bytes(mem_q[rd_addr], wr_data, wr_be);
        end
    end

    // -----------------------------------------------------------------------
    // Read pipeline
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  vld_p1_q;
            logic [DATA_WIDTH-1:0] data_p1_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p1_q   <= 1'b0;
                    data_p1_q  <= '0;
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                end else begin
                    // Stage 1: array read
                    vld_p1_q <= rd_fire;
                    if (rd_fire) begin
                        data_p1_q <= rd_word_d;
                    end
                    // Stage 2: output register, holds between reads
                    rd_valid_q <= vld_p1_q;
                    if (vld_p1_q) begin
                        rd_data_q <= data_p1_q;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                end else begin
                    // Stage 1: array read straight into the output register
                    rd_valid_q <= rd_fire;
                    if (rd_fire) begin
                        rd_data_q <= rd_word_d;
                    end
                end
            end
        end
    endgenerate

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_dp_be.sv
module tb_ram_dp_be;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;

    // index 0: lat1/old, 1: lat1/new, 2: lat2/old, 3: lat2/new
    logic        busy [4];
    logic        vld  [4];
    logic [31:0] dat  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(1), .RDW_MODE(0)) u_l1_r0 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat[0]), .rd_valid(vld[0]));
    ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(1), .RDW_MODE(1)) u_l1_r1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat[1]), .rd_valid(vld[1]));
    ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(2), .RDW_MODE(0)) u_l2_r0 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat[2]), .rd_valid(vld[2]));
    ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(2), .RDW_MODE(1)) u_l2_r1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy[3]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dat[3]), .rd_valid(vld[3]));

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [DEPTH];
    int          clear_left = 0;   // words still to be zeroed; busy while nonzero
    logic        e1_v = 1'b0, e2_v = 1'b0;
    logic [31:0] e1_old = '0, e1_new = '0, e2_old = '0, e2_new = '0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            clear_left = DEPTH;
            e1_v = 1'b0; e1_old = '0; e1_new = '0;
            e2_v = 1'b0; e2_old = '0; e2_new = '0;
        end else begin
            // two-cycle view is the one-cycle view delayed by one edge
            e2_v = e1_v;
            if (e1_v) begin
                e2_old = e1_old;
                e2_new = e1_new;
            end
            e1_v = 1'b0;
            if (clear_left > 0) begin
                mem_m[DEPTH - clear_left] = '0;
                clear_left = clear_left - 1;
            end else begin
                if (rd_en) begin
                    e1_v   = 1'b1;
                    e1_old = mem_m[rd_addr];
                    e1_new = (wr_en && wr_addr == rd_addr) ?
                             merge(mem_m[rd_addr], wr_data, wr_be) : mem_m[rd_addr];
                end
                if (wr_en) mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_be);
                if (clr) clear_left = DEPTH;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic        ev;
        logic [31:0] ed;
        for (int k = 0; k < 4; k++) begin
            ev = (k < 2) ? e1_v : e2_v;
            if (k < 2) ed = (k % 2 == 1) ? e1_new : e1_old;
            else       ed = (k % 2 == 1) ? e2_new : e2_old;
            chk($sformatf("model busy[%0d]", k), {31'b0, busy[k]}, {31'b0, (clear_left != 0)});
            chk($sformatf("model rd_valid[%0d]", k), {31'b0, vld[k]}, {31'b0, ev});
            chk($sformatf("model rd_data[%0d]", k), dat[k], ed);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
    endtask

    task automatic cyc(input logic we, input logic [4:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic re, input logic [4:0] ra,
                       input logic c);
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra; clr = c;
        tick();
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_be = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b1, a, be, d, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic rd(input logic [4:0] a);
        cyc(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, a, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    // counts cycles with busy high, starting at the negedge just after release
    task automatic count_busy(output int n);
        n = 0;
        tick();
        while (busy[0] && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // reset state
        #1 rst = 1'b1;
        #1;
        chk("reset busy", {31'b0, busy[0]}, 32'd1);
        chk("reset rd_valid", {31'b0, vld[0]}, 32'd0);
        chk("reset rd_data", dat[0], 32'h0);
        repeat (2) tick();
        @(posedge clk);
        #2 rst = 1'b0;
        count_busy(n);
        chk("busy length after reset", n, 32'd32);

        // array reads zero after the clear
        rd(5'd0);
        chk("rd0 valid", {31'b0, vld[0]}, 32'd1);
        chk("rd0 data", dat[0], 32'h0);
        rd(5'd17);
        chk("rd17 data", dat[0], 32'h0);
        rd(5'd31);
        chk("rd31 valid", {31'b0, vld[0]}, 32'd1);
        chk("rd31 data", dat[0], 32'h0);

        // byte enables
        wr(5'd3, 32'hDEADBEEF, 4'b1111);
        wr(5'd3, 32'h0000AA00, 4'b0010);
        wr(5'd4, 32'hFFFFFFFF, 4'b0000);
        rd(5'd3);
        chk("be merge", dat[0], 32'hDEADAAEF);
        rd(5'd4);
        chk("be zero no-op", dat[0], 32'h0);
        chk("be merge lat2", dat[2], 32'hDEADAAEF);

        // read during write
        wr(5'd5, 32'h11111111, 4'b1111);
        cyc(1'b1, 5'd5, 4'b1111, 32'h22222222, 1'b1, 5'd5, 1'b0);
        chk("rdw old", dat[0], 32'h11111111);
        chk("rdw new", dat[1], 32'h22222222);
        wr(5'd5, 32'h11111111, 4'b1111);
        cyc(1'b1, 5'd5, 4'b0001, 32'h22222222, 1'b1, 5'd5, 1'b0);
        chk("rdw partial new", dat[1], 32'h11111122);
        chk("rdw partial old", dat[0], 32'h11111111);
        idle();
        chk("rdw partial new lat2", dat[3], 32'h11111122);

        // two-cycle latency, back-to-back reads
        wr(5'd1, 32'hA, 4'hF);
        wr(5'd2, 32'hB, 4'hF);
        wr(5'd3, 32'hC, 4'hF);
        rd(5'd1);
        chk("lat2 first edge valid", {31'b0, vld[2]}, 32'd0);
        rd(5'd2);
        chk("lat2 A valid", {31'b0, vld[2]}, 32'd1);
        chk("lat2 A data", dat[2], 32'hA);
        rd(5'd3);
        chk("lat2 B data", dat[2], 32'hB);
        idle();
        chk("lat2 C data", dat[2], 32'hC);
        idle();
        chk("lat2 idle valid", {31'b0, vld[2]}, 32'd0);
        chk("lat2 hold C", dat[2], 32'hC);

        // clear mid-operation
        wr(5'd7, 32'h12345678, 4'hF);
        cyc(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 1'b1);
        chk("clr busy rises", {31'b0, busy[0]}, 32'd1);
        chk("read with clr data", dat[0], 32'h12345678);
        cyc(1'b1, 5'd8, 4'hF, 32'h55555555, 1'b1, 5'd7, 1'b0);
        chk("busy read ignored", {31'b0, vld[0]}, 32'd0);
        chk("lat2 read completes in busy", dat[2], 32'h12345678);
        repeat (18) idle();
        cyc(1'b1, 5'd2, 4'hF, 32'h00000099, 1'b0, 5'd0, 1'b1);
        n = 0;
        while (busy[0] && n < 100) begin
            n++;
            idle();
        end
        chk("clr busy ends", {31'b0, busy[0]}, 32'd0);
        chk("rd_data held over clr", dat[0], 32'h12345678);
        rd(5'd7);
        chk("addr7 cleared", dat[0], 32'h0);
        rd(5'd8);
        chk("addr8 not written", dat[0], 32'h0);
        rd(5'd2);
        chk("late busy write ignored", dat[0], 32'h0);

        // async reset in the middle of a clear
        wr(5'd9, 32'hCAFEF00D, 4'hF);
        rd(5'd9);
        chk("pre-reset data", dat[0], 32'hCAFEF00D);
        cyc(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b1);
        repeat (9) tick();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", {31'b0, busy[0]}, 32'd1);
        chk("async rst rd_data", dat[0], 32'h0);
        chk("async rst rd_data lat2", dat[2], 32'h0);
        chk("async rst rd_valid", {31'b0, vld[0]}, 32'd0);
        compare_model();
        repeat (2) tick();
        @(posedge clk);
        #2 rst = 1'b0;
        count_busy(n);
        chk("busy length after mid-clear reset", n, 32'd32);
        rd(5'd9);
        chk("addr9 cleared", dat[0], 32'h0);
        chk("addr9 valid", {31'b0, vld[0]}, 32'd1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
Parametrised simple-dual-port RAM: one write port and one read port, both on the same clock. Adds byte-enable writes, a selectable read latency and a selectable read-during-write policy. A hardware clear engine zeroes the array after reset and on request. Drop-in storage for register files, scratchpads and buffer backings in the datapath; replaces the single-port tri-state-bus RAM, with no inout ports.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH words
READ_LATENCY, 1, cycles from rd_en to rd_valid/rd_data; legal values 1 or 2
RDW_MODE, 0, same-address read and write in one cycle: 0 = read returns old data, 1 = read returns new (byte-merged) data

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
clr  input  1  request clear of whole array (single-cycle pulse sufficient)
busy  output  1  clear engine running; all requests ignored while high
wr_en  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_be  input  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  read data; holds last value between reads
rd_valid  output  1  one-cycle pulse, rd_data valid this cycle

Behaviour:
- Reset, asynchronous, active-high: FSM goes to CLEAR with clear counter = 0. busy=1, rd_data=0, rd_valid=0, all read pipeline registers = 0. Outputs change immediately on rst assertion, without waiting for clk.
- FSM states:
  - CLEAR: writes 0 to mem[cnt] each cycle, cnt increments by 1. When cnt == DEPTH-1 is written, go to IDLE. busy falls on the next edge, so busy is high for exactly DEPTH cycles after rst deasserts.
  - IDLE: serves reads and writes. clr=1 in IDLE moves the FSM to CLEAR with cnt=0; busy rises on the next edge.
  - clr while in CLEAR is ignored; it does not restart the counter.
  - rst asserted during CLEAR restarts the clear from address 0.
- Requests while busy: wr_en and rd_en are ignored. No array update, no rd_valid. A read issued before busy rose still completes through the pipeline.
- Write: with wr_en=1 in IDLE, byte i of mem[wr_addr] takes wr_data byte i where wr_be[i]=1; other bytes are unchanged. wr_be=0 is a no-op.
- Read, READ_LATENCY=1: rd_en sampled at edge N; rd_data and rd_valid are registered and present after edge N.
- Read, READ_LATENCY=2: one extra output register stage, so data appears after edge N+1. The pipeline is fully pipelined and accepts one read per cycle.
- Read during write, same address, same cycle:
  - RDW_MODE=0: the read returns array contents before the write.
  - RDW_MODE=1: the read returns the stored word with enabled bytes replaced by wr_data (bypass mux).
  - Different addresses: the two ports are independent.
- rd_data: holds its value when rd_valid=0. It is not cleared by clr; only rst zeroes it.
- Address range: DEPTH = 2**ADDR_WIDTH, so there are no out-of-range addresses. Writes and reads at address DEPTH-1 need no special handling.

Test Plan:
- Reset/clear (DATA_WIDTH=32, ADDR_WIDTH=5): assert rst, release → busy high exactly 32 cycles, then reads of addr 0, 17 and 31 return 0x00000000 with rd_valid after 1 cycle.
- Byte enables: write addr 3 = 0xDEADBEEF with be=4'b1111, then write 0x0000AA00 with be=4'b0010 → read addr 3 returns 0xDEADAAEF.
- Read during write: mem[5]=0x11111111; same cycle write 0x22222222 (be=4'b1111) and read addr 5 → RDW_MODE=0 returns 0x11111111, RDW_MODE=1 returns 0x22222222. With be=4'b0001 and RDW_MODE=1 → 0x11111122.
- Latency: READ_LATENCY=2, back-to-back reads of addrs 1, 2, 3 holding 0xA, 0xB, 0xC → rd_valid high on cycles N+2, N+3, N+4 with data 0xA, 0xB, 0xC; rd_data holds 0xC afterwards.
- clr mid-operation: write addr 7 = 0x12345678, pulse clr, issue write addr 8 and read addr 7 while busy → no rd_valid, no write. After busy falls, addrs 7 and 8 read 0.
- Async reset mid-clear: assert rst 10 cycles into CLEAR between clock edges → busy stays 1, rd_data and rd_valid go to 0 immediately; after release busy lasts a full 32 cycles.
